// File: rtl/muldiv_pkg.sv
// Package: muldiv_pkg
// Shared constants, sign-mode codes, FSM state type and small helpers for the
// iterative RV64M multiply/divide unit.
//  XLEN          operand/result width (W-variants use the low XLEN/2 bits)
//  SGN_*         sign-mode codes carried on io_*_signed
//  ITER_D/ITER_W iteration counts for full-width and W operations
//  state_e       per-engine FSM state {IDLE, BUSY, DONE}
package muldiv_pkg;

  localparam int XLEN   = 64;
  localparam int HALF   = XLEN / 2;
  localparam int ITER_D = 64;
  localparam int ITER_W = 32;
  localparam int CNT_W  = $clog2(ITER_D);

  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Sign-extend the low half of a word to full width.
  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Counter value seen during the final BUSY iteration.
  function automatic logic [CNT_W-1:0] last_cnt(input logic w);
    return w ? CNT_W'(ITER_W - 1) : CNT_W'(ITER_D - 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Interface: muldiv_if
// Request/response bundle between the EXU and muldiv_iter_unit.
//  io_flush            abort both engines
//  io_mul_*            multiply request (valid/w/signed/a/b) and response
//                      (ready/out_vld/res_h/res_l)
//  io_div_*            divide request (valid/w/signed/dend/dsor) and response
//                      (ready/out_vld/quot/rem)
// Modports: master = EXU side, slave = compute unit side.
interface muldiv_if;
  import muldiv_pkg::*;

  logic            io_flush;

  logic            io_mul_valid;
  logic            io_mul_w;
  logic [1:0]      io_mul_signed;
  logic [XLEN-1:0] io_mul_a;
  logic [XLEN-1:0] io_mul_b;
  logic            io_mul_ready;
  logic            io_mul_out_vld;
  logic [XLEN-1:0] io_mul_res_h;
  logic [XLEN-1:0] io_mul_res_l;

  logic            io_div_valid;
  logic            io_div_w;
  logic [1:0]      io_div_signed;
  logic [XLEN-1:0] io_div_dend;
  logic [XLEN-1:0] io_div_dsor;
  logic            io_div_ready;
  logic            io_div_out_vld;
  logic [XLEN-1:0] io_div_quot;
  logic [XLEN-1:0] io_div_rem;

  modport master (
    output io_flush,
    output io_mul_valid, io_mul_w, io_mul_signed, io_mul_a, io_mul_b,
    input  io_mul_ready, io_mul_out_vld, io_mul_res_h, io_mul_res_l,
    output io_div_valid, io_div_w, io_div_signed, io_div_dend, io_div_dsor,
    input  io_div_ready, io_div_out_vld, io_div_quot, io_div_rem
  );

  modport slave (
    input  io_flush,
    input  io_mul_valid, io_mul_w, io_mul_signed, io_mul_a, io_mul_b,
    output io_mul_ready, io_mul_out_vld, io_mul_res_h, io_mul_res_l,
    input  io_div_valid, io_div_w, io_div_signed, io_div_dend, io_div_dsor,
    output io_div_ready, io_div_out_vld, io_div_quot, io_div_rem
  );

endinterface

// File: rtl/muldiv_divider.sv
// Module: muldiv_divider
// Iterative restoring radix-2 divider on operand magnitudes, one quotient bit
// per cycle, with RV64M sign fix-up and divide-by-zero handling.
//  clock, reset   rising-edge clock, synchronous active-high reset
//  flush          abort to IDLE, results untouched
//  req_*          request (valid, w, signed mode, dividend, divisor)
//  ready/out_vld  IDLE indicator / one-cycle DONE pulse
//  quot/rem       registered results, held until the next DONE
// Build option: MULDIV_EARLY_OUT_EN makes a zero divisor skip BUSY.
module muldiv_divider
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  input  logic            req_w,
  input  logic [1:0]      req_signed,
  input  logic [XLEN-1:0] req_dend,
  input  logic [XLEN-1:0] req_dsor,
  output logic            ready,
  output logic            out_vld,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  state_e          state_q, state_d;
  logic            accept;
  logic            dend_neg, dsor_neg;
  logic [XLEN-1:0] dend_val, dsor_val, dend_mag, dsor_mag;

  logic [XLEN-1:0] rem_q, quot_q, dsor_q;
  logic            quot_neg_q, rem_neg_q, dz_q, w_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]   shifted, diff;
  logic            ge, last;
  logic [XLEN-1:0] rem_nxt, quot_nxt, quot_s, rem_s, quot_fin, rem_fin;
  logic [XLEN-1:0] quot_r, rem_r;

  assign accept = req_valid && (state_q == IDLE) && !flush;
  assign ready  = (state_q == IDLE);
  assign out_vld = (state_q == DONE);
  assign quot   = quot_r;
  assign rem    = rem_r;

  // W operands are sign- or zero-extended from bit 31 before taking magnitudes.
  always_comb begin
    dend_neg = (req_signed == SGN_SS) && (req_w ? req_dend[HALF-1] : req_dend[XLEN-1]);
    dsor_neg = (req_signed == SGN_SS) && (req_w ? req_dsor[HALF-1] : req_dsor[XLEN-1]);
    dend_val = req_w ? {{HALF{dend_neg}}, req_dend[HALF-1:0]} : req_dend;
    dsor_val = req_w ? {{HALF{dsor_neg}}, req_dsor[HALF-1:0]} : req_dsor;
    dend_mag = dend_neg ? -dend_val : dend_val;
    dsor_mag = dsor_neg ? -dsor_val : dsor_val;
  end

  // One restoring step. rem_q < divisor keeps the shifted value within XLEN+1
  // bits, so diff[XLEN] is a borrow flag. With a zero divisor every step
  // subtracts nothing, rem collects the dividend magnitude and only the
  // quotient needs overriding. min / -1 needs no special case: |min| / 1
  // negated is min again and the remainder is 0.
  always_comb begin
    shifted  = {rem_q, quot_q[XLEN-1]};
    diff     = shifted - {1'b0, dsor_q};
    ge       = !diff[XLEN];
    rem_nxt  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quot_nxt = {quot_q[XLEN-2:0], ge};
    last     = (cnt_q == last_cnt(w_q));
    quot_s   = dz_q ? '1 : (quot_neg_q ? -quot_nxt : quot_nxt);
    rem_s    = rem_neg_q ? -rem_nxt : rem_nxt;
    quot_fin = w_q ? sext_w(quot_s) : quot_s;
    rem_fin  = w_q ? sext_w(rem_s) : rem_s;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          state_d = (dsor_val == '0) ? DONE : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY:    if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      // W dividends are parked in the top half so 32 shifts consume them.
      quot_q     <= req_w ? {dend_mag[HALF-1:0], {HALF{1'b0}}} : dend_mag;
      rem_q      <= '0;
      dsor_q     <= dsor_mag;
      quot_neg_q <= dend_neg ^ dsor_neg;
      rem_neg_q  <= dend_neg;
      dz_q       <= (dsor_val == '0);
      w_q        <= req_w;
      cnt_q      <= '0;
    end else if (state_q == BUSY) begin
      quot_q <= quot_nxt;
      rem_q  <= rem_nxt;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quot_r <= '0;
      rem_r  <= '0;
    end else if ((state_q == BUSY) && last && !flush) begin
      quot_r <= quot_fin;
      rem_r  <= rem_fin;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (accept && (dsor_val == '0)) begin
      quot_r <= '1;
      rem_r  <= req_w ? sext_w(req_dend) : req_dend;
    end
`endif
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Module: muldiv_iter_unit
// Iterative RV64M multiply and divide engines side by side. Each engine has
// its own valid/ready request and a one-cycle out_vld completion pulse; the
// EXU keeps result muxing and stall control.
//  clock  rising-edge clock
//  reset  synchronous, active-high; both engines IDLE, results cleared
//  bus    muldiv_if.slave: io_flush, io_mul_* and io_div_* request/response
// Build option: MULDIV_EARLY_OUT_EN lets a multiply with a zero operand or a
// divide by zero finish one cycle after accept instead of iterating.
// The shift-add multiplier lives here; the divider is muldiv_divider.
module muldiv_iter_unit
  import muldiv_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  muldiv_if.slave  bus
);

  state_e            mul_state_q, mul_state_d;
  logic              mul_accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_val, b_val, a_mag, b_mag;

  logic [2*XLEN-1:0] mul_prod_q;
  logic [XLEN-1:0]   mul_mcand_q;
  logic              mul_neg_q, mul_w_q;
  logic [CNT_W-1:0]  mul_cnt_q;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod_nxt, mul_full, mul_sgnd;
  logic [XLEN-1:0]   res_l_nxt, res_h_nxt;
  logic              mul_last;
  logic [XLEN-1:0]   mul_res_l_q, mul_res_h_q;

  assign mul_accept         = bus.io_mul_valid && (mul_state_q == IDLE) && !bus.io_flush;
  assign bus.io_mul_ready   = (mul_state_q == IDLE);
  assign bus.io_mul_out_vld = (mul_state_q == DONE);
  assign bus.io_mul_res_l   = mul_res_l_q;
  assign bus.io_mul_res_h   = mul_res_h_q;

  // Mode 10 signs only a; mode 01 falls through as unsigned.
  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else coverage); a missed path would infer a latch.
  always_comb begin
    a_neg = ((bus.io_mul_signed == SGN_SS) || (bus.io_mul_signed == SGN_SU)) &&
            (bus.io_mul_w ? bus.io_mul_a[HALF-1] : bus.io_mul_a[XLEN-1]);
    b_neg = (bus.io_mul_signed == SGN_SS) &&
            (bus.io_mul_w ? bus.io_mul_b[HALF-1] : bus.io_mul_b[XLEN-1]);
    a_val = bus.io_mul_w ? {{HALF{a_neg}}, bus.io_mul_a[HALF-1:0]} : bus.io_mul_a;
    b_val = bus.io_mul_w ? {{HALF{b_neg}}, bus.io_mul_b[HALF-1:0]} : bus.io_mul_b;
    a_mag = a_neg ? -a_val : a_val;
    b_mag = b_neg ? -b_val : b_val;
  end

  // Shift-add step on {acc, multiplier}. A W multiplier fits in 32 bits, so
  // after 32 steps the product sits 32 bits above the bottom of the register.
  always_comb begin
    mul_sum      = {1'b0, mul_prod_q[2*XLEN-1:XLEN]} +
                   (mul_prod_q[0] ? {1'b0, mul_mcand_q} : '0);
    mul_prod_nxt = {mul_sum, mul_prod_q[XLEN-1:1]};
    mul_full     = mul_w_q ? {{XLEN{1'b0}}, mul_prod_nxt[XLEN+HALF-1:HALF]} : mul_prod_nxt;
    mul_sgnd     = mul_neg_q ? -mul_full : mul_full;
    res_l_nxt    = mul_w_q ? sext_w(mul_sgnd[XLEN-1:0]) : mul_sgnd[XLEN-1:0];
    res_h_nxt    = mul_w_q ? {XLEN{mul_sgnd[HALF-1]}} : mul_sgnd[2*XLEN-1:XLEN];
    mul_last     = (mul_cnt_q == last_cnt(mul_w_q));
  end

  always_comb begin
    mul_state_d = mul_state_q;
    unique case (mul_state_q)
      IDLE: begin
        if (mul_accept) begin
`ifdef MULDIV_EARLY_OUT_EN
          mul_state_d = ((a_val == '0) || (b_val == '0)) ? DONE : BUSY;
`else
          mul_state_d = BUSY;
`endif
        end
      end
      BUSY:    if (mul_last) mul_state_d = DONE;
      DONE:    mul_state_d = IDLE;
      default: mul_state_d = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (bus.io_flush) mul_state_d = IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clock) begin
    if (reset) mul_state_q <= IDLE;
    else       mul_state_q <= mul_state_d;
  end

  // NOTE: the working datapath has no reset; it is fully reloaded on accept
  // and never observed outside BUSY. Only the visible results are cleared.
  always_ff @(posedge clock) begin
    if (mul_accept) begin
      mul_prod_q  <= {{XLEN{1'b0}}, b_mag};
      mul_mcand_q <= a_mag;
      mul_neg_q   <= a_neg ^ b_neg;
      mul_w_q     <= bus.io_mul_w;
      mul_cnt_q   <= '0;
    end else if (mul_state_q == BUSY) begin
      mul_prod_q <= mul_prod_nxt;
      mul_cnt_q  <= mul_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mul_res_l_q <= '0;
      mul_res_h_q <= '0;
    end else if ((mul_state_q == BUSY) && mul_last && !bus.io_flush) begin
      mul_res_l_q <= res_l_nxt;
      mul_res_h_q <= res_h_nxt;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (mul_accept && ((a_val == '0) || (b_val == '0))) begin
      mul_res_l_q <= '0;
      mul_res_h_q <= '0;
    end
`endif
  end

  muldiv_divider u_divider (
    .clock      (clock),
    .reset      (reset),
    .flush      (bus.io_flush),
    .req_valid  (bus.io_div_valid),
    .req_w      (bus.io_div_w),
    .req_signed (bus.io_div_signed),
    .req_dend   (bus.io_div_dend),
    .req_dsor   (bus.io_div_dsor),
    .ready      (bus.io_div_ready),
    .out_vld    (bus.io_div_out_vld),
    .quot       (bus.io_div_quot),
    .rem        (bus.io_div_rem)
  );

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Testbench: tb_muldiv_iter_unit
// Directed-vector bench for muldiv_iter_unit: reset state, signed/unsigned
// and W multiplies and divides, special cases, simultaneous requests, flush,
// held-valid back-to-back issue and reset during an operation. Expected
// latencies follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_muldiv_iter_unit;
  import muldiv_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT_D = 1;
  localparam int EO_LAT_W = 1;
`else
  localparam int EO_LAT_D = 65;
  localparam int EO_LAT_W = 33;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  muldiv_if bus ();

  muldiv_iter_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    bus.io_flush = 1'b0;
    bus.io_mul_valid = 1'b0;
    bus.io_div_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got mul=%b div=%b want 1/1", bus.io_mul_ready, bus.io_div_ready);
    end
    checks++;
    if (bus.io_mul_out_vld !== 1'b0 || bus.io_div_out_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_vld: got mul=%b div=%b want 0/0", bus.io_mul_out_vld, bus.io_div_out_vld);
    end
    checks++;
    if (bus.io_mul_res_l !== 64'd0 || bus.io_mul_res_h !== 64'd0) begin
      failures++;
      $display("FAIL reset_mul_res: got %h_%h want 0", bus.io_mul_res_h, bus.io_mul_res_l);
    end
    checks++;
    if (bus.io_div_quot !== 64'd0 || bus.io_div_rem !== 64'd0) begin
      failures++;
      $display("FAIL reset_div_res: got q=%h r=%h want 0", bus.io_div_quot, bus.io_div_rem);
    end
  endtask

  // Issues one multiply from an idle negedge, scrambles the inputs after
  // accept, and returns at the negedge of the cycle after DONE.
  task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] sgn, input logic w,
                         input logic [63:0] exp_l, input logic [63:0] exp_h, input int exp_lat);
    int lat;
    bit busy_ok;
    bus.io_mul_a = a; bus.io_mul_b = b; bus.io_mul_signed = sgn; bus.io_mul_w = w;
    bus.io_mul_valid = 1'b1;
    checks++;
    if (bus.io_mul_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle: got %b want 1", name, bus.io_mul_ready);
    end
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      bus.io_mul_valid = 1'b0;
      bus.io_mul_a = ~a; bus.io_mul_b = ~b; bus.io_mul_signed = ~sgn; bus.io_mul_w = ~w;
      if (bus.io_mul_ready !== 1'b0) busy_ok = 1'b0;
    end while (bus.io_mul_out_vld !== 1'b1 && lat < 200);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s_ready_busy: got ready=1 while busy want 0", name);
    end
    checks++;
    if (bus.io_mul_res_l !== exp_l || bus.io_mul_res_h !== exp_h) begin
      failures++;
      $display("FAIL %s_result: got h=%h l=%h want h=%h l=%h", name,
               bus.io_mul_res_h, bus.io_mul_res_l, exp_h, exp_l);
    end
    @(negedge clock);
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_mul_out_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after: got ready=%b vld=%b want 1/0", name,
               bus.io_mul_ready, bus.io_mul_out_vld);
    end
  endtask

  task automatic run_div(input string name, input logic [63:0] dend, input logic [63:0] dsor,
                         input logic [1:0] sgn, input logic w,
                         input logic [63:0] exp_q, input logic [63:0] exp_r, input int exp_lat);
    int lat;
    bit busy_ok;
    bus.io_div_dend = dend; bus.io_div_dsor = dsor; bus.io_div_signed = sgn; bus.io_div_w = w;
    bus.io_div_valid = 1'b1;
    checks++;
    if (bus.io_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_idle: got %b want 1", name, bus.io_div_ready);
    end
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clock);
      lat++;
      bus.io_div_valid = 1'b0;
      bus.io_div_dend = ~dend; bus.io_div_dsor = ~dsor; bus.io_div_signed = ~sgn; bus.io_div_w = ~w;
      if (bus.io_div_ready !== 1'b0) busy_ok = 1'b0;
    end while (bus.io_div_out_vld !== 1'b1 && lat < 200);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s_ready_busy: got ready=1 while busy want 0", name);
    end
    checks++;
    if (bus.io_div_quot !== exp_q || bus.io_div_rem !== exp_r) begin
      failures++;
      $display("FAIL %s_result: got q=%h r=%h want q=%h r=%h", name,
               bus.io_div_quot, bus.io_div_rem, exp_q, exp_r);
    end
    @(negedge clock);
    checks++;
    if (bus.io_div_ready !== 1'b1 || bus.io_div_out_vld !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after: got ready=%b vld=%b want 1/0", name,
               bus.io_div_ready, bus.io_div_out_vld);
    end
  endtask

  task automatic test_mul();
    run_mul("mul_uu_6x7", 64'd6, 64'd7, SGN_UU, 1'b0, 64'd42, 64'd0, 65);
    run_mul("mul_ss_m3x5", -64'sd3, 64'd5, SGN_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1, ONES, 65);
    run_mul("mul_su_m2x3", -64'sd2, 64'd3, SGN_SU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, ONES, 65);
    run_mul("mul_su_2xm1", 64'd2, ONES, SGN_SU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_mul("mul_01_m1xm1", ONES, ONES, 2'b01, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
  endtask

  task automatic test_mul_w();
    run_mul("mulw_uu_2p31x2", 64'h0000_0000_8000_0000, 64'd2, SGN_UU, 1'b1, 64'd0, 64'd0, 33);
    run_mul("mulw_ss_m1x3", 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_0000_0003, SGN_SS, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, ONES, 33);
    run_mul("mulw_uu_max", 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, SGN_UU, 1'b1,
            64'd1, 64'd0, 33);
  endtask

  task automatic test_div();
    run_div("div_ss_m7d2", -64'sd7, 64'd2, SGN_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 65);
    run_div("div_uu_100d7", 64'd100, 64'd7, SGN_UU, 1'b0, 64'd14, 64'd2, 65);
    run_div("div_uu_m7d2", -64'sd7, 64'd2, SGN_UU, 1'b0, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 65);
    run_div("div_ss_7dm2", 64'd7, -64'sd2, SGN_SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_div("divw_ss_m7d2", 64'hAAAA_AAAA_FFFF_FFF9, 64'h5555_5555_0000_0002, SGN_SS, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFD, ONES, 33);
    run_div("divw_uu_maxd1", 64'h0000_0000_FFFF_FFFF, 64'd1, SGN_UU, 1'b1, ONES, 64'd0, 33);
  endtask

  task automatic test_div_special();
    run_div("div_uu_5d0", 64'd5, 64'd0, SGN_UU, 1'b0, ONES, 64'd5, EO_LAT_D);
    run_div("div_ss_m5d0", -64'sd5, 64'd0, SGN_SS, 1'b0, ONES, 64'hFFFF_FFFF_FFFF_FFFB, EO_LAT_D);
    run_div("div_ss_ovf", 64'h8000_0000_0000_0000, ONES, SGN_SS, 1'b0,
            64'h8000_0000_0000_0000, 64'd0, 65);
    run_div("divw_uu_d0", 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_0000_0000, SGN_UU, 1'b1,
            ONES, 64'hFFFF_FFFF_8000_0000, EO_LAT_W);
    run_div("divw_ss_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, SGN_SS, 1'b1,
            64'hFFFF_FFFF_8000_0000, 64'd0, 33);
  endtask

  task automatic test_early_out();
    run_mul("mul_eo_0x9", 64'd0, 64'd9, SGN_UU, 1'b0, 64'd0, 64'd0, EO_LAT_D);
    run_div("div_eo_9d0", 64'd9, 64'd0, SGN_UU, 1'b0, ONES, 64'd9, EO_LAT_D);
  endtask

  task automatic start_both(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] dend, input logic [63:0] dsor);
    bus.io_mul_a = a; bus.io_mul_b = b; bus.io_mul_signed = SGN_UU; bus.io_mul_w = 1'b0;
    bus.io_div_dend = dend; bus.io_div_dsor = dsor; bus.io_div_signed = SGN_UU; bus.io_div_w = 1'b0;
    bus.io_mul_valid = 1'b1;
    bus.io_div_valid = 1'b1;
  endtask

  task automatic test_simultaneous();
    int mv, dv;
    start_both(64'd6, 64'd7, 64'd100, 64'd7);
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL sim_ready_idle: got mul=%b div=%b want 1/1", bus.io_mul_ready, bus.io_div_ready);
    end
    mv = -1;
    dv = -1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.io_mul_valid = 1'b0;
        bus.io_div_valid = 1'b0;
        checks++;
        if (bus.io_mul_ready !== 1'b0 || bus.io_div_ready !== 1'b0) begin
          failures++;
          $display("FAIL sim_both_accepted: got ready mul=%b div=%b want 0/0",
                   bus.io_mul_ready, bus.io_div_ready);
        end
      end
      if (bus.io_mul_out_vld === 1'b1 && mv < 0) mv = n;
      if (bus.io_div_out_vld === 1'b1 && dv < 0) dv = n;
    end
    checks++;
    if (mv != 65 || dv != 65) begin
      failures++;
      $display("FAIL sim_latency: got mul=%0d div=%0d want 65/65", mv, dv);
    end
    checks++;
    if (bus.io_mul_res_l !== 64'd42 || bus.io_mul_res_h !== 64'd0 ||
        bus.io_div_quot !== 64'd14 || bus.io_div_rem !== 64'd2) begin
      failures++;
      $display("FAIL sim_results: got l=%0d h=%0d q=%0d r=%0d want 42 0 14 2",
               bus.io_mul_res_l, bus.io_mul_res_h, bus.io_div_quot, bus.io_div_rem);
    end
  endtask

  task automatic watch_no_vld(input string name);
    bit seen;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (bus.io_mul_out_vld !== 1'b0 || bus.io_div_out_vld !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL %s_no_vld: got out_vld pulse want none", name);
    end
  endtask

  // Relies on test_simultaneous having left 42/0 and 14/2 in the result regs.
  task automatic test_flush();
    start_both(64'd3, 64'd3, 64'd50, 64'd5);
    @(negedge clock);
    bus.io_mul_valid = 1'b0;
    bus.io_div_valid = 1'b0;
    repeat (9) @(negedge clock);
    bus.io_flush = 1'b1;
    @(negedge clock);
    bus.io_flush = 1'b0;
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_div_ready !== 1'b1 ||
        bus.io_mul_out_vld !== 1'b0 || bus.io_div_out_vld !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: got ready=%b/%b vld=%b/%b want 1/1 0/0", bus.io_mul_ready,
               bus.io_div_ready, bus.io_mul_out_vld, bus.io_div_out_vld);
    end
    checks++;
    if (bus.io_mul_res_l !== 64'd42 || bus.io_mul_res_h !== 64'd0) begin
      failures++;
      $display("FAIL flush_mul_hold: got h=%h l=%h want 0/42", bus.io_mul_res_h, bus.io_mul_res_l);
    end
    checks++;
    if (bus.io_div_quot !== 64'd14 || bus.io_div_rem !== 64'd2) begin
      failures++;
      $display("FAIL flush_div_hold: got q=%h r=%h want 14/2", bus.io_div_quot, bus.io_div_rem);
    end
    watch_no_vld("flush_midop");
    // Flush and request in the same idle cycle: the flush wins.
    start_both(64'd3, 64'd3, 64'd50, 64'd5);
    bus.io_flush = 1'b1;
    @(negedge clock);
    bus.io_flush = 1'b0;
    bus.io_mul_valid = 1'b0;
    bus.io_div_valid = 1'b0;
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_div_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_beats_accept: got ready mul=%b div=%b want 1/1",
               bus.io_mul_ready, bus.io_div_ready);
    end
    watch_no_vld("flush_accept");
  endtask

  task automatic test_back_to_back();
    int v1, v2;
    logic [63:0] r1, r2;
    v1 = -1; v2 = -1; r1 = '0; r2 = '0;
    bus.io_mul_a = 64'd2; bus.io_mul_b = 64'd3; bus.io_mul_signed = SGN_UU; bus.io_mul_w = 1'b0;
    bus.io_mul_valid = 1'b1;
    checks++;
    if (bus.io_mul_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_idle: got %b want 1", bus.io_mul_ready);
    end
    for (int n = 1; n <= 140; n++) begin
      @(negedge clock);
      if (n == 1) begin
        bus.io_mul_a = 64'd10;
        bus.io_mul_b = 64'd10;
      end
      if (bus.io_mul_out_vld === 1'b1) begin
        if (v1 < 0) begin
          v1 = n; r1 = bus.io_mul_res_l;
        end else if (v2 < 0) begin
          v2 = n; r2 = bus.io_mul_res_l;
        end
      end
      if (n == 66) begin
        checks++;
        if (bus.io_mul_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_t66: got %b want 1", bus.io_mul_ready);
        end
      end
      if (n == 67) begin
        bus.io_mul_valid = 1'b0;
        checks++;
        if (bus.io_mul_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_reaccept: got ready=%b want 0", bus.io_mul_ready);
        end
      end
    end
    checks++;
    if (v1 != 65 || r1 !== 64'd6) begin
      failures++;
      $display("FAIL b2b_first: got vld@%0d res=%0d want vld@65 res=6", v1, r1);
    end
    checks++;
    if (v2 != 131 || r2 !== 64'd100) begin
      failures++;
      $display("FAIL b2b_second: got vld@%0d res=%0d want vld@131 res=100", v2, r2);
    end
  endtask

  task automatic test_reset_midop();
    start_both(64'd6, 64'd7, 64'd100, 64'd7);
    @(negedge clock);
    bus.io_mul_valid = 1'b0;
    bus.io_div_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (bus.io_mul_ready !== 1'b1 || bus.io_div_ready !== 1'b1 ||
        bus.io_mul_out_vld !== 1'b0 || bus.io_div_out_vld !== 1'b0) begin
      failures++;
      $display("FAIL rst_midop_idle: got ready=%b/%b vld=%b/%b want 1/1 0/0", bus.io_mul_ready,
               bus.io_div_ready, bus.io_mul_out_vld, bus.io_div_out_vld);
    end
    checks++;
    if (bus.io_mul_res_l !== 64'd0 || bus.io_mul_res_h !== 64'd0 ||
        bus.io_div_quot !== 64'd0 || bus.io_div_rem !== 64'd0) begin
      failures++;
      $display("FAIL rst_midop_results: got l=%h h=%h q=%h r=%h want 0", bus.io_mul_res_l,
               bus.io_mul_res_h, bus.io_div_quot, bus.io_div_rem);
    end
    watch_no_vld("rst_midop");
  endtask

  initial begin
    reset = 1'b1;
    bus.io_flush = 1'b0;
    bus.io_mul_valid = 1'b0; bus.io_mul_w = 1'b0; bus.io_mul_signed = SGN_UU;
    bus.io_mul_a = '0; bus.io_mul_b = '0;
    bus.io_div_valid = 1'b0; bus.io_div_w = 1'b0; bus.io_div_signed = SGN_UU;
    bus.io_div_dend = '0; bus.io_div_dsor = '0;
    test_reset();
    test_mul();
    test_mul_w();
    test_div();
    test_div_special();
    test_early_out();
    test_simultaneous();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
